// File: rtl/audio_i2s_frontend_if.sv
// Sample/handshake bundle between the I2S front end and the AI core.
interface audio_i2s_frontend_if;
  logic [15:0] audio_sample;
  logic        sample_valid;
  logic        start_analysis;
  logic        frame_active;
  logic        ai_busy;

  modport master (
    output audio_sample, sample_valid, start_analysis, frame_active,
    input  ai_busy
  );

  modport slave (
    input  audio_sample, sample_valid, start_analysis, frame_active,
    output ai_busy
  );
endinterface

// File: rtl/audio_i2s_frontend.sv
// Mono I2S deserialiser with DC removal, saturating power-of-two gain and a
// frame controller that feeds exactly FRAME_LEN samples per analysis.
module audio_i2s_frontend #(
  parameter int unsigned FRAME_LEN = 512,
  parameter int unsigned DC_SHIFT  = 8,
  parameter int unsigned ACC_W     = 16 + DC_SHIFT + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i2s_sck,
  input  logic                  i2s_ws,
  input  logic                  i2s_sd,
  input  logic                  enable,
  input  logic [2:0]            gain_shift,
  audio_i2s_frontend_if.master  core,
  output logic [15:0]           drop_count,
  output logic [15:0]           sat_count,
  output logic [15:0]           frames_done
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic signed [23:0] G_MAX = 24'sd32767;
  localparam logic signed [23:0] G_MIN = -24'sd32768;

  typedef enum logic [1:0] {IDLE, ARM, STREAM, WAIT} state_t;

  logic [1:0]  sck_sync, ws_sync, sd_sync;
  logic        sck_prev;
  logic        sck_rise, ws_s, sd_s;

  logic [15:0] shreg;
  logic [4:0]  bit_cnt;
  logic        ws_last;
  logic        raw_valid;

  logic signed [ACC_W-1:0] dc_acc, dc_est, raw_ext;
  logic signed [16:0]      hp;
  logic signed [23:0]      g;
  logic                    sat_hi, sat_lo;
  logic [15:0]             sample_next;

  state_t           state;
  logic [CNT_W-1:0] sample_cnt;

  assign sck_rise = sck_sync[1] & ~sck_prev;
  assign ws_s     = ws_sync[1];
  assign sd_s     = sd_sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], i2s_sck};
      ws_sync  <= {ws_sync[0], i2s_ws};
      sd_sync  <= {sd_sync[0], i2s_sd};
      sck_prev <= sck_sync[1];
    end
  end

  // A ws change marks the one-bit delay slot; only the first 16 left bits count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      ws_last   <= 1'b0;
      raw_valid <= 1'b0;
    end else begin
      raw_valid <= 1'b0;
      if (sck_rise) begin
        ws_last <= ws_s;
        if (ws_s != ws_last) begin
          bit_cnt <= '0;
        end else if (!ws_s && bit_cnt < 5'd16) begin
          shreg     <= {shreg[14:0], sd_s};
          bit_cnt   <= bit_cnt + 5'd1;
          raw_valid <= (bit_cnt == 5'd15);
        end
      end
    end
  end

  always_comb begin
    raw_ext     = {{(ACC_W-16){shreg[15]}}, shreg};
    dc_est      = dc_acc >>> DC_SHIFT;
    hp          = 17'(raw_ext - dc_est);
    g           = {{7{hp[16]}}, hp} <<< gain_shift;
    sat_hi      = (g > G_MAX);
    sat_lo      = (g < G_MIN);
    sample_next = sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : g[15:0]);
  end

  // The filter path runs on every word; only the valid/drop decision depends on state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      sample_cnt          <= '0;
      dc_acc              <= '0;
      core.audio_sample   <= '0;
      core.sample_valid   <= 1'b0;
      core.start_analysis <= 1'b0;
      core.frame_active   <= 1'b0;
      drop_count          <= '0;
      sat_count           <= '0;
      frames_done         <= '0;
    end else begin
      core.sample_valid   <= 1'b0;
      core.start_analysis <= 1'b0;

      if (raw_valid) begin
        dc_acc            <= dc_acc + raw_ext - dc_est;
        core.audio_sample <= sample_next;
        if ((sat_hi || sat_lo) && sat_count != 16'hFFFF)
          sat_count <= sat_count + 16'd1;
        if (state == STREAM)
          core.sample_valid <= 1'b1;
        else if (drop_count != 16'hFFFF)
          drop_count <= drop_count + 16'd1;
      end

      case (state)
        IDLE: begin
          if (enable && !core.ai_busy) begin
            state               <= ARM;
            core.start_analysis <= 1'b1;
            core.frame_active   <= 1'b1;
          end
        end
        ARM: begin
          sample_cnt <= '0;
          state      <= STREAM;
        end
        STREAM: begin
          if (raw_valid) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == CNT_W'(FRAME_LEN - 1)) begin
              state       <= WAIT;
              frames_done <= frames_done + 16'd1;
            end
          end
        end
        WAIT: begin
          if (!core.ai_busy) begin
            state             <= IDLE;
            core.frame_active <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/audio_i2s_frontend.md
Name: audio_i2s_frontend

Overview:
Upstream stage of the audio AI core. Deserialises a mono (left-channel) I2S PCM stream, removes DC offset, applies a power-of-two gain with saturation, and delivers 16-bit samples as single-cycle `sample_valid` pulses. A frame controller issues `start_analysis`, then forwards exactly FRAME_LEN samples per analysis. It does not re-arm until the AI core drops `ai_busy`.

Parameters:
FRAME_LEN, 512, samples forwarded per analysis frame; must match the core's buffer depth.
DC_SHIFT, 8, time constant of the DC tracker; dc_est = dc_acc >>> DC_SHIFT.
ACC_W, 16+DC_SHIFT+1, width of the signed DC accumulator.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
i2s_sck  in  1  I2S bit clock, asynchronous, at most clk/4
i2s_ws  in  1  I2S word select, asynchronous; 0 = left channel
i2s_sd  in  1  I2S serial data, asynchronous, MSB first
enable  in  1  permits new frames to start
gain_shift  in  3  left-shift gain, 0..7, applied after DC removal
ai_busy  in  1  busy flag from the AI core
audio_sample  out  16  conditioned signed sample
sample_valid  out  1  one-cycle pulse; asserted only in STREAM
start_analysis  out  1  one-cycle pulse starting a core analysis
frame_active  out  1  high in ARM, STREAM and WAIT
drop_count  out  16  samples discarded outside STREAM; saturates at 0xFFFF
sat_count  out  16  samples clipped by gain; saturates at 0xFFFF
frames_done  out  16  completed frames; wraps

Behaviour:
- Reset: every output is 0. State is IDLE. Synchronisers, shift register, bit_cnt and dc_acc are cleared. Reset mid-frame aborts the frame immediately, with no partial pulses.
- Input synchronisation: sck, ws and sd each pass through a 2-flop synchroniser. An sck rise is detected when the synchronised sck is 1 and its previous registered value was 0.
- Deserialiser, evaluated on each detected sck rise:
  - If the synchronised ws differs from ws_last (the value captured at the previous rise), set bit_cnt=0 and capture nothing. This is the I2S one-bit delay slot.
  - Otherwise, if ws=0 and bit_cnt<16, shift sd into the LSB and increment bit_cnt.
  - When bit_cnt goes 15->16, raw_valid pulses on the following cycle, with raw = shift register.
  - Bits beyond 16 are ignored. ws=1 words are ignored.
  - ws_last updates on every rise.
- DC removal and gain, both on raw_valid:
  - dc_est = dc_acc >>> DC_SHIFT, using the pre-update dc_acc.
  - hp = raw - dc_est, as a 17-bit signed value.
  - dc_acc <= dc_acc + raw - dc_est.
  - g = hp <<< gain_shift. If g > 32767 output 0x7FFF; if g < -32768 output 0x8000; in both cases sat_count increments.
  - audio_sample is registered the cycle after raw_valid. Total latency is the detected rise that completes bit 16, plus 2 clk cycles.
  - The filter runs regardless of state or enable.
- Frame FSM:
  - IDLE: if enable=1 and ai_busy=0, go to ARM.
  - ARM (one cycle): start_analysis=1, sample count cleared, go to STREAM. A sample arriving in ARM is dropped.
  - STREAM: each processed sample pulses sample_valid in its output cycle and increments the count. After the FRAME_LEN-th pulse, go to WAIT and increment frames_done.
  - WAIT: if ai_busy=0, go to IDLE. Re-arming therefore needs at least one more cycle.
  - Samples output in IDLE or WAIT are not flagged valid, and drop_count increments.
  - Deasserting enable during ARM, STREAM or WAIT does not truncate the frame, so the core never hangs. enable only gates IDLE->ARM.
- audio_sample holds its last value between pulses.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles with a stream running -> all outputs 0 and no pulses while in reset.
- Single word: enable=1, ai_busy=0, send left word 0x1234 with gain_shift=0 -> start_analysis pulses once, then sample_valid with audio_sample=0x1234 exactly 2 clk after the 16th-bit rise is detected. Right word 0xFFFF is ignored.
- Gain saturation: first sample after reset, raw=0x4000, gain_shift=1 -> audio_sample=0x7FFF and sat_count=1. raw=0xC000, gain_shift=1 -> 0x8000 and sat_count=2.
- DC convergence: constant raw=0x0100 with DC_SHIFT=8 -> output decays monotonically toward 0, with |audio_sample| <= 1 after 4096 samples.
- Full frame: FRAME_LEN=512 with the core model asserting busy the cycle after start -> exactly 512 sample_valid pulses and frames_done=1. Further samples increment drop_count until busy falls, then a new start_analysis follows.
- Enable dropped mid-frame: deassert enable after 100 samples -> frame still completes with 512 pulses, then the FSM stays in IDLE with no new start_analysis.
